pico_cmd_streamer: RTL

- Initiator-side encoder for the stream-carried PicoBus command protocol.
- Accepts simple read/write requests plus write data and serialises them onto a 128-bit outbound stream as command words followed by write-data beats.
- Collects read-return beats from the inbound stream and delivers them with a last marker.
- Sits in test/host-emulation logic opposite the stream-to-PicoBus bridge, one transaction at a time.

---
 rtl/pico_cmd_streamer_if.sv | 38 +++
 rtl/pico_cmd_streamer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pico_cmd_streamer_if.sv
// Handshake bundle between a PicoBus host model and pico_cmd_streamer:
// request, write data, outbound command stream, inbound return stream, read data.
interface pico_cmd_streamer_if #(
  parameter int unsigned W = 128
);
  logic          req_valid;
  logic          req_ready;
  logic          req_rd;
  logic [31:0]   req_addr;
  logic [31:0]   req_size;
  logic          wd_valid;
  logic          wd_ready;
  logic [W-1:0]  wd_data;
  logic          so_valid;
  logic          so_ready;
  logic [W-1:0]  so_data;
  logic          si_valid;
  logic          si_ready;
  logic [W-1:0]  si_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic          rd_last;

  modport master (
    output req_valid, req_rd, req_addr, req_size, wd_valid, wd_data,
           so_ready, si_valid, si_data, rd_ready,
    input  req_ready, wd_ready, so_valid, so_data, si_ready,
           rd_valid, rd_data, rd_last
  );

  modport slave (
    input  req_valid, req_rd, req_addr, req_size, wd_valid, wd_data,
           so_ready, si_valid, si_data, rd_ready,
    output req_ready, wd_ready, so_valid, so_data, si_ready,
           rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/pico_cmd_streamer.sv
// PicoBus initiator: serialises read/write requests onto a 128-bit stream and
// collects read returns. Define PICO_CMD_TIMEOUT_EN to enable the read-return timeout.
module pico_cmd_streamer #(
  parameter int unsigned W              = 128,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               s_clk,
  input  logic               s_rst_n,
  pico_cmd_streamer_if.slave bus,
  output logic               busy,
  output logic               stray_beat,
  output logic               err_timeout
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  state_e        state_q, state_d;
  logic [28:0]   cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          so_valid_q, so_valid_d;
  logic [W-1:0]  so_data_q, so_data_d;
  logic          stray_q;
  logic          to_hit;
  logic [28:0]   beats;
  logic [W-1:0]  cmd_word;

  // ceil(size/16) without a 33-bit adder: upper bits plus a carry for any remainder
  assign beats    = {1'b0, bus.req_size[31:4]} + 29'(|bus.req_size[3:0]);
  assign cmd_word = {{(W-65){1'b0}}, bus.req_rd, bus.req_addr[31:4], 4'h0, bus.req_size};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    so_valid_d    = so_valid_q;
    so_data_d     = so_data_q;
    bus.req_ready = 1'b0;
    bus.wd_ready  = 1'b0;
    bus.so_valid  = so_valid_q;
    bus.so_data   = so_data_q;
    bus.si_ready  = 1'b1;
    bus.rd_valid  = 1'b0;
    bus.rd_data   = bus.si_data;
    bus.rd_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // held low while reset is asserted even though the state already reads IDLE
        bus.req_ready = s_rst_n;
        if (bus.req_valid) begin
          so_valid_d = 1'b1;
          so_data_d  = cmd_word;
          cnt_d      = beats;
          rd_d       = bus.req_rd;
          state_d    = CMD;
        end
      end
      CMD: begin
        if (bus.so_ready) begin
          so_valid_d = 1'b0;
          if (cnt_q == '0)  state_d = IDLE;
          else if (rd_q)    state_d = RDATA;
          else              state_d = WDATA;
        end
      end
      WDATA: begin
        bus.so_valid = bus.wd_valid;
        bus.so_data  = bus.wd_data;
        bus.wd_ready = bus.so_ready;
        if (bus.wd_valid && bus.so_ready) begin
          cnt_d = cnt_q - 29'd1;
          if (cnt_q == 29'd1) state_d = IDLE;
        end
      end
      RDATA: begin
        bus.rd_valid = bus.si_valid;
        bus.si_ready = bus.rd_ready;
        bus.rd_last  = (cnt_q == 29'd1);
        if (bus.si_valid && bus.rd_ready) begin
          cnt_d = cnt_q - 29'd1;
          if (cnt_q == 29'd1) state_d = IDLE;
        end else if (to_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_data_q  <= '0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      so_valid_q <= so_valid_d;
      so_data_q  <= so_data_d;
      stray_q    <= (state_q != RDATA) && bus.si_valid;
    end
  end

`ifdef PICO_CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt_q;
  logic          err_q;

  assign to_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q != RDATA || (bus.si_valid && bus.si_ready)) to_cnt_q <= '0;
      else                                                    to_cnt_q <= to_cnt_q + TW'(1);
      if (state_q == RDATA && to_hit && !(bus.si_valid && bus.si_ready)) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign stray_beat = stray_q;

endmodule
